// File: rtl/button_pulse_gen.sv
// Button conditioner: two-flop synchroniser, debounce FSM and hold-to-repeat timer.
// Emits one-cycle PULSE per accepted press/repeat, RELEASE per accepted release, and debounced LEVEL.
module button_pulse_gen #(
    parameter int DB_CYCLES     = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    input  logic REPEAT_EN,
    output logic PULSE,
    output logic RELEASE,
    output logic LEVEL
);

    localparam int CW   = $clog2(DB_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    state_t        state_q;
    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q;
    logic [RW-1:0] rpt_q;
    logic          rep_q;      // set once the first (delay) repeat has fired; selects the period target
    logic          pulse_q, release_q, level_q;

    logic [RW-1:0] rpt_d;
    logic          rep_d;
    logic          rpt_fire;

    // Repeat timer step, applied on every held cycle (including the cycle that leaves REL_CHK).
    always_comb begin
        rpt_d    = '0;
        rep_d    = 1'b0;
        rpt_fire = 1'b0;
        if (REPEAT_EN) begin
            if (rpt_q == (rep_q ? PER_LAST : DLY_LAST)) begin
                rpt_fire = 1'b1;
                rep_d    = 1'b1;
            end else begin
                rpt_d = rpt_q + 1'b1;
                rep_d = rep_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            rpt_q     <= '0;
            rep_q     <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            s1_q      <= BTN;
            s2_q      <= s1_q;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s2_q) begin
                        state_q <= PRESS_CHK;
                        cnt_q   <= CNT_ONE;
                    end
                end
                PRESS_CHK: begin
                    if (!s2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HELD;
                        pulse_q <= 1'b1;
                        level_q <= 1'b1;
                        rpt_q   <= '0;
                        rep_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!s2_q) begin
                        state_q <= REL_CHK;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        rpt_q   <= rpt_d;
                        rep_q   <= rep_d;
                        pulse_q <= rpt_fire;
                    end
                end
                REL_CHK: begin
                    if (s2_q) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                        rpt_q   <= rpt_d;
                        rep_q   <= rep_d;
                        pulse_q <= rpt_fire;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= IDLE;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                        rpt_q     <= '0;
                        rep_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PULSE   = pulse_q;
    assign RELEASE = release_q;
    assign LEVEL   = level_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Tick index k counts rising edges from the first edge that samples the new BTN level (edge 0).
module tb_button_pulse_gen;

    logic CLK = 1'b0;
    logic RST_N;
    logic BTN;
    logic REPEAT_EN;
    logic PULSE, RELEASE, LEVEL;

    int tests = 0;
    int fails = 0;
    int press_pulses = 0;

    button_pulse_gen #(
        .DB_CYCLES    (4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(8)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .BTN      (BTN),
        .REPEAT_EN(REPEAT_EN),
        .PULSE    (PULSE),
        .RELEASE  (RELEASE),
        .LEVEL    (LEVEL)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        BTN = 1'b0;
        REPEAT_EN = 1'b0;
        for (int k = 0; k < 12; k++) begin
            BTN = k[0];
            tick();
            tests++;
            if ({PULSE, RELEASE, LEVEL} !== 3'b000) begin
                fails++;
                $display("FAIL reset_hold k=%0d got {P,R,L}=%b expected 000", k, {PULSE, RELEASE, LEVEL});
            end
        end
        BTN = 1'b0;
        RST_N = 1'b1;
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_clean_press();
        int cnt;
        int first;
        cnt = 0;
        first = -1;
        REPEAT_EN = 1'b0;
        BTN = 1'b1;
        for (int k = 0; k < 110; k++) begin
            tick();
            if (PULSE === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
            tests++;
            if (LEVEL !== (k >= 5)) begin
                fails++;
                $display("FAIL press_level k=%0d got %b expected %b", k, LEVEL, (k >= 5));
            end
        end
        press_pulses += cnt;
        tests++;
        if (cnt != 1) begin
            fails++;
            $display("FAIL press_count got %0d expected 1", cnt);
        end
        tests++;
        if (first != 5) begin
            fails++;
            $display("FAIL press_latency got %0d expected 5", first);
        end
    endtask

    task automatic test_release();
        int rel_cnt;
        int rel_at;
        rel_cnt = 0;
        rel_at = -1;
        BTN = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (PULSE === 1'b1) press_pulses++;
            if (RELEASE === 1'b1) begin
                rel_cnt++;
                if (rel_at < 0) rel_at = k;
            end
            tests++;
            if (LEVEL !== (k < 5)) begin
                fails++;
                $display("FAIL release_level k=%0d got %b expected %b", k, LEVEL, (k < 5));
            end
        end
        tests++;
        if (rel_cnt != 1 || rel_at != 5) begin
            fails++;
            $display("FAIL release_pulse got count=%0d at=%0d expected count=1 at=5", rel_cnt, rel_at);
        end
        tests++;
        if (press_pulses != 1) begin
            fails++;
            $display("FAIL pulses_per_press got %0d expected 1", press_pulses);
        end
    endtask

    task automatic test_bounce();
        int cnt;
        int first;
        cnt = 0;
        for (int k = 0; k < 24; k++) begin
            BTN = (k < 3) || (k >= 5 && k < 8);
            tick();
            if (PULSE === 1'b1) cnt++;
            tests++;
            if (LEVEL !== 1'b0) begin
                fails++;
                $display("FAIL bounce_level k=%0d got %b expected 0", k, LEVEL);
            end
        end
        tests++;
        if (cnt != 0) begin
            fails++;
            $display("FAIL bounce_reject got %0d pulses expected 0", cnt);
        end
        cnt = 0;
        first = -1;
        BTN = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (PULSE === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        tests++;
        if (cnt != 1 || first != 5) begin
            fails++;
            $display("FAIL bounce_then_press got count=%0d at=%0d expected count=1 at=5", cnt, first);
        end
        BTN = 1'b0;
        for (int k = 0; k < 20; k++) tick();
    endtask

    task automatic test_auto_repeat();
        int exp_at[6] = '{5, 25, 33, 41, 49, 57};
        int got[$];
        int rel_at;
        rel_at = -1;
        REPEAT_EN = 1'b1;
        BTN = 1'b1;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (PULSE === 1'b1) got.push_back(k);
            if (RELEASE === 1'b1 && rel_at < 0) rel_at = k;
            if (PULSE === 1'b1 && RELEASE === 1'b1) begin
                tests++;
                fails++;
                $display("FAIL repeat_pulse_and_release k=%0d both high", k);
            end
            if (k == 59) BTN = 1'b0;
        end
        tests++;
        if (got.size() != 6) begin
            fails++;
            $display("FAIL repeat_count got %0d expected 6", got.size());
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (i >= got.size() || got[i] != exp_at[i]) begin
                fails++;
                $display("FAIL repeat_time idx=%0d got %0d expected %0d", i,
                         (i < got.size()) ? got[i] : -1, exp_at[i]);
            end
        end
        tests++;
        if (rel_at != 65) begin
            fails++;
            $display("FAIL repeat_release got %0d expected 65", rel_at);
        end
        for (int k = 0; k < 5; k++) tick();
    endtask

    task automatic test_release_glitch();
        int exp_at[4] = '{5, 27, 35, 43};
        int got[$];
        int rel_cnt;
        rel_cnt = 0;
        REPEAT_EN = 1'b1;
        BTN = 1'b1;
        for (int k = 0; k < 46; k++) begin
            tick();
            if (PULSE === 1'b1) got.push_back(k);
            if (RELEASE === 1'b1) rel_cnt++;
            if (k >= 5) begin
                tests++;
                if (LEVEL !== 1'b1) begin
                    fails++;
                    $display("FAIL glitch_level k=%0d got %b expected 1", k, LEVEL);
                end
            end
            if (k == 10) BTN = 1'b0;
            if (k == 12) BTN = 1'b1;
        end
        tests++;
        if (rel_cnt != 0) begin
            fails++;
            $display("FAIL glitch_release got %0d expected 0", rel_cnt);
        end
        tests++;
        if (got.size() != 4) begin
            fails++;
            $display("FAIL glitch_count got %0d expected 4", got.size());
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i >= got.size() || got[i] != exp_at[i]) begin
                fails++;
                $display("FAIL glitch_time idx=%0d got %0d expected %0d", i,
                         (i < got.size()) ? got[i] : -1, exp_at[i]);
            end
        end
        BTN = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (RELEASE === 1'b1) rel_cnt++;
        end
        tests++;
        if (rel_cnt != 1) begin
            fails++;
            $display("FAIL glitch_final_release got %0d expected 1", rel_cnt);
        end
        REPEAT_EN = 1'b0;
    endtask

    task automatic test_async_reset();
        int cnt;
        int first;
        REPEAT_EN = 1'b0;
        BTN = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        tests++;
        if (LEVEL !== 1'b1) begin
            fails++;
            $display("FAIL async_pre_level got %b expected 1", LEVEL);
        end
        #2;
        RST_N = 1'b0;
        #1;
        tests++;
        if ({PULSE, RELEASE, LEVEL} !== 3'b000) begin
            fails++;
            $display("FAIL async_clear got {P,R,L}=%b expected 000", {PULSE, RELEASE, LEVEL});
        end
        tick();
        tick();
        #2;
        RST_N = 1'b1;
        cnt = 0;
        first = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (PULSE === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        tests++;
        if (cnt != 1 || first != 5) begin
            fails++;
            $display("FAIL reset_release_press got count=%0d at=%0d expected count=1 at=5", cnt, first);
        end
        BTN = 1'b0;
        for (int k = 0; k < 10; k++) tick();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_auto_repeat();
        test_release_glitch();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
